// File: rtl/titan_pkg.sv
// Shared definitions for the titan fetch path: FSM states, fault codes, NOP word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package titan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [3:0]  FAULT_MISALIGNED = 4'd0;
    localparam logic [3:0]  FAULT_ACCESS     = 4'd1;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

    // A fetch address is usable only on a 32-bit word boundary
    function automatic logic is_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/titan_fetch_timeout.sv
// Bus-wait watchdog: counts cycles from start, flags expiry after LIMIT cycles.
// Latency: expired rises combinationally in the LIMIT-th cycle after start.
// Backpressure: none; clear stops and rewinds the count, start has priority.
module titan_fetch_timeout
    import titan_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;
    logic       running;

    assign expired = running && (count == LAST_COUNT);

    // Count while armed; hold at the limit so expired stays up until cleared
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count   <= 8'd0;
            running <= 1'b0;
        end else if (start) begin
            count   <= 8'd0;
            running <= 1'b1;
        end else if (clear) begin
            count   <= 8'd0;
            running <= 1'b0;
        end else if (running && !expired) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/titan_fetch_unit.sv
// Instruction fetch unit: one Wishbone classic read per request, result or fault to IF/ID.
// Latency: request to cyc 1 cycle, ack/err to result 1 cycle; misaligned fault 1 cycle.
// Backpressure: fetch_stall_i holds the result in HOLD; optional bus timeout via TITAN_FETCH_TIMEOUT_EN.
module titan_fetch_unit
    import titan_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_stall_i,
    input  logic        fetch_kill_i,
    output logic [31:0] instruction_o,
    output logic [31:0] fetch_pc_o,
    output logic        instruction_valid_o,
    output logic        fault_valid_o,
    output logic [3:0]  fault_code_o,
    output logic        busy_o,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("titan_fetch_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    fetch_state_t state;
    logic         bus_cyc;
    logic         accept_req;
    logic         tmo_expired;

    // A new request is taken from IDLE, or from HOLD in the cycle the result is consumed
    assign accept_req = fetch_req_i && !fetch_kill_i &&
                        ((state == ST_IDLE) || (state == ST_HOLD && !fetch_stall_i));

`ifdef TITAN_FETCH_TIMEOUT_EN
    logic tmo_start;
    logic tmo_clear;

    assign tmo_start = accept_req && is_aligned(fetch_pc_i);
    assign tmo_clear = (state == ST_IDLE) || (state == ST_HOLD);

    titan_fetch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (tmo_start),
        .clear   (tmo_clear),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    assign iwbm_cyc_o = bus_cyc;
    assign iwbm_stb_o = bus_cyc;
    assign busy_o     = (state != ST_IDLE);

    // Fetch FSM; bus strobes and result outputs are all registered here
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= ST_IDLE;
            bus_cyc             <= 1'b0;
            iwbm_addr_o         <= RESET_ADDR;
            fetch_pc_o          <= RESET_ADDR;
            instruction_o       <= NOP_INSN;
            instruction_valid_o <= 1'b0;
            fault_valid_o       <= 1'b0;
            fault_code_o        <= FAULT_MISALIGNED;
        end else begin
            case (state)
                ST_IDLE: begin
                    // stay idle unless the accept block below launches something
                end
                ST_WAIT: begin
                    if (iwbm_ack_i || iwbm_err_i) begin
                        bus_cyc <= 1'b0;
                        if (fetch_kill_i) begin
                            state <= ST_IDLE;
                        end else begin
                            state      <= ST_HOLD;
                            fetch_pc_o <= iwbm_addr_o;
                            if (iwbm_err_i) begin
                                fault_valid_o <= 1'b1;
                                fault_code_o  <= FAULT_ACCESS;
                            end else begin
                                instruction_o       <= iwbm_dat_i;
                                instruction_valid_o <= 1'b1;
                            end
                        end
                    end else if (tmo_expired) begin
                        bus_cyc <= 1'b0;
                        if (fetch_kill_i) begin
                            state <= ST_IDLE;
                        end else begin
                            state         <= ST_HOLD;
                            fetch_pc_o    <= iwbm_addr_o;
                            fault_valid_o <= 1'b1;
                            fault_code_o  <= FAULT_ACCESS;
                        end
                    end else if (fetch_kill_i) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    // the bus cycle must finish cleanly; its data is thrown away
                    if (iwbm_ack_i || iwbm_err_i || tmo_expired) begin
                        bus_cyc <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (fetch_kill_i || !fetch_stall_i) begin
                        state               <= ST_IDLE;
                        instruction_valid_o <= 1'b0;
                        fault_valid_o       <= 1'b0;
                        fault_code_o        <= FAULT_MISALIGNED;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Launch overrides the IDLE fall-through above, giving back-to-back fetches
            if (accept_req) begin
                if (is_aligned(fetch_pc_i)) begin
                    state       <= ST_WAIT;
                    bus_cyc     <= 1'b1;
                    iwbm_addr_o <= fetch_pc_i;
                end else begin
                    state         <= ST_HOLD;
                    fetch_pc_o    <= fetch_pc_i;
                    fault_valid_o <= 1'b1;
                    fault_code_o  <= FAULT_MISALIGNED;
                end
            end
        end
    end

endmodule

// File: tb/tb_titan_fetch_unit.sv
// Directed bench for titan_fetch_unit: vector table plus stall/kill/reset/timeout sequences.
// Latency: inputs driven 1 time unit after posedge, outputs checked 1 time unit after the next posedge.
// Backpressure: fetch_stall_i exercised directly by the hand-written sequences.
module tb_titan_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_stall;
    logic        fetch_kill;
    logic [31:0] instruction;
    logic [31:0] fetch_pc_out;
    logic        instruction_valid;
    logic        fault_valid;
    logic [3:0]  fault_code;
    logic        busy;
    logic [31:0] iwbm_addr;
    logic        iwbm_cyc;
    logic        iwbm_stb;
    logic [31:0] iwbm_dat;
    logic        iwbm_ack;
    logic        iwbm_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    titan_fetch_unit #(
        .RESET_ADDR     (32'h0000_0000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .fetch_req_i         (fetch_req),
        .fetch_pc_i          (fetch_pc),
        .fetch_stall_i       (fetch_stall),
        .fetch_kill_i        (fetch_kill),
        .instruction_o       (instruction),
        .fetch_pc_o          (fetch_pc_out),
        .instruction_valid_o (instruction_valid),
        .fault_valid_o       (fault_valid),
        .fault_code_o        (fault_code),
        .busy_o              (busy),
        .iwbm_addr_o         (iwbm_addr),
        .iwbm_cyc_o          (iwbm_cyc),
        .iwbm_stb_o          (iwbm_stb),
        .iwbm_dat_i          (iwbm_dat),
        .iwbm_ack_i          (iwbm_ack),
        .iwbm_err_i          (iwbm_err)
    );

    typedef struct {
        logic        rst, req;
        logic [31:0] pc;
        logic        stall, kill, ack, err;
        logic [31:0] dat;
        logic        e_cyc;
        logic [31:0] e_addr;
        logic        e_iv, e_fv;
        logic [3:0]  e_code;
        logic [31:0] e_insn, e_pco;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic q, input logic [31:0] pc,
                       input logic s, input logic k, input logic a, input logic e,
                       input logic [31:0] d, input logic ec, input logic [31:0] ea,
                       input logic eiv, input logic efv, input logic [3:0] ecode,
                       input logic [31:0] einsn, input logic [31:0] epco, input logic eb);
        vec_t v;
        v.rst = r; v.req = q; v.pc = pc; v.stall = s; v.kill = k; v.ack = a; v.err = e;
        v.dat = d; v.e_cyc = ec; v.e_addr = ea; v.e_iv = eiv; v.e_fv = efv;
        v.e_code = ecode; v.e_insn = einsn; v.e_pco = epco; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic q, input logic [31:0] pc,
                         input logic s, input logic k, input logic a, input logic e,
                         input logic [31:0] d);
        rst = r; fetch_req = q; fetch_pc = pc; fetch_stall = s; fetch_kill = k;
        iwbm_ack = a; iwbm_err = e; iwbm_dat = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [104:0] got_b, exp_b;
        int           cyc_cnt;

        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //   rst req pc          stl kil ack err dat             cyc addr         iv fv code insn          pco          busy
        add(1, 0, 32'h0,      0, 0, 0, 0, 32'h0,          0, 32'h0,      0, 0, 0, NOP,          32'h0,   0); // reset
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          0, 32'h0,      0, 0, 0, NOP,          32'h0,   0);
        add(0, 1, 32'h100,    0, 0, 0, 0, 32'h0,          1, 32'h100,    0, 0, 0, NOP,          32'h0,   1); // fetch 0x100
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          1, 32'h100,    0, 0, 0, NOP,          32'h0,   1);
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          1, 32'h100,    0, 0, 0, NOP,          32'h0,   1);
        add(0, 0, 32'h0,      0, 0, 1, 0, 32'h00500093,   0, 32'h100,    1, 0, 0, 32'h00500093, 32'h100, 1); // ack
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          0, 32'h100,    0, 0, 0, 32'h00500093, 32'h100, 0); // consumed
        add(0, 1, 32'h102,    0, 0, 0, 0, 32'h0,          0, 32'h100,    0, 1, 0, 32'h00500093, 32'h102, 1); // misaligned
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          0, 32'h100,    0, 0, 0, 32'h00500093, 32'h102, 0);
        add(0, 1, 32'h200,    0, 0, 0, 0, 32'h0,          1, 32'h200,    0, 0, 0, 32'h00500093, 32'h102, 1); // fetch 0x200
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          1, 32'h200,    0, 0, 0, 32'h00500093, 32'h102, 1);
        add(0, 0, 32'h0,      0, 0, 0, 1, 32'h0,          0, 32'h200,    0, 1, 1, 32'h00500093, 32'h200, 1); // err
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          0, 32'h200,    0, 0, 0, 32'h00500093, 32'h200, 0);
        add(0, 1, 32'h200,    0, 0, 0, 0, 32'h0,          1, 32'h200,    0, 0, 0, 32'h00500093, 32'h200, 1);
        add(0, 0, 32'h0,      0, 0, 1, 1, 32'hDEADBEEF,   0, 32'h200,    0, 1, 1, 32'h00500093, 32'h200, 1); // ack+err
        add(0, 1, 32'h204,    0, 0, 0, 0, 32'h0,          1, 32'h204,    0, 0, 0, 32'h00500093, 32'h200, 1); // b2b accept
        add(0, 0, 32'h0,      0, 0, 1, 0, 32'h11111111,   0, 32'h204,    1, 0, 0, 32'h11111111, 32'h204, 1);
        add(0, 1, 32'h208,    0, 0, 0, 0, 32'h0,          1, 32'h208,    0, 0, 0, 32'h11111111, 32'h204, 1);
        add(0, 0, 32'h0,      0, 0, 1, 0, 32'h22222222,   0, 32'h208,    1, 0, 0, 32'h22222222, 32'h208, 1);
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          0, 32'h208,    0, 0, 0, 32'h22222222, 32'h208, 0);
        add(0, 1, 32'h280,    0, 0, 0, 0, 32'h0,          1, 32'h280,    0, 0, 0, 32'h22222222, 32'h208, 1); // fetch then kill
        add(0, 0, 32'h0,      0, 1, 0, 0, 32'h0,          1, 32'h280,    0, 0, 0, 32'h22222222, 32'h208, 1);
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          1, 32'h280,    0, 0, 0, 32'h22222222, 32'h208, 1);
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          1, 32'h280,    0, 0, 0, 32'h22222222, 32'h208, 1);
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          1, 32'h280,    0, 0, 0, 32'h22222222, 32'h208, 1);
        add(0, 0, 32'h0,      0, 0, 1, 0, 32'h33333333,   0, 32'h280,    0, 0, 0, 32'h22222222, 32'h208, 0); // dropped
        add(0, 1, 32'h300,    0, 0, 0, 0, 32'h0,          1, 32'h300,    0, 0, 0, 32'h22222222, 32'h208, 1);
        add(0, 0, 32'h0,      0, 0, 1, 0, 32'h44444444,   0, 32'h300,    1, 0, 0, 32'h44444444, 32'h300, 1);
        add(0, 0, 32'h0,      0, 0, 0, 0, 32'h0,          0, 32'h300,    0, 0, 0, 32'h44444444, 32'h300, 0);
        add(0, 1, 32'h400,    0, 1, 0, 0, 32'h0,          0, 32'h300,    0, 0, 0, 32'h44444444, 32'h300, 0); // kill in IDLE
        add(0, 1, 32'h400,    0, 0, 0, 0, 32'h0,          1, 32'h400,    0, 0, 0, 32'h44444444, 32'h300, 1);
        add(0, 0, 32'h0,      0, 1, 1, 0, 32'h55555555,   0, 32'h400,    0, 0, 0, 32'h44444444, 32'h300, 0); // kill+ack
        add(0, 1, 32'h3,      0, 1, 0, 0, 32'h0,          0, 32'h400,    0, 0, 0, 32'h44444444, 32'h300, 0); // kill misaligned

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].pc, vecs[i].stall, vecs[i].kill,
                  vecs[i].ack, vecs[i].err, vecs[i].dat);
            step();
            got_b = {iwbm_cyc, iwbm_stb, iwbm_addr, instruction_valid, fault_valid,
                     fault_code, instruction, fetch_pc_out, busy};
            exp_b = {vecs[i].e_cyc, vecs[i].e_cyc, vecs[i].e_addr, vecs[i].e_iv, vecs[i].e_fv,
                     vecs[i].e_code, vecs[i].e_insn, vecs[i].e_pco, vecs[i].e_busy};
            n_checks++;
            if (got_b === exp_b) n_pass++;
            else $display("FAIL vec%0d: got %h expected %h", i, got_b, exp_b);
        end

        // Result held under stall for 5 cycles, then consumed exactly once
        drive(0, 1, 32'h500, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 32'h0, 1, 0, 1, 0, 32'h66666666);
        step();
        drive(0, 0, 32'h0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_stable%0d", i),
                  {instruction_valid, fault_valid, busy, 29'd0}, {3'b101, 29'd0});
            check($sformatf("hold_insn%0d", i), instruction, 32'h66666666);
            check($sformatf("hold_pc%0d", i), fetch_pc_out, 32'h500);
            if (i < 4) step();
        end
        fetch_stall = 1'b0;
        step();
        check("hold_consumed", {31'd0, instruction_valid | busy}, 32'd0);
        step();
        check("hold_no_repeat", {31'd0, instruction_valid | fault_valid}, 32'd0);

        // Kill while holding a stalled result
        drive(0, 1, 32'h600, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 32'h0, 1, 0, 1, 0, 32'h77777777);
        step();
        check("kill_hold_pre", {31'd0, instruction_valid}, 32'd1);
        drive(0, 0, 32'h0, 1, 1, 0, 0, 0);
        step();
        check("kill_hold_post", {29'd0, instruction_valid, fault_valid, busy}, 32'd0);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0);

        // Reset in the middle of a bus cycle, then a stray ack
        drive(0, 1, 32'h700, 0, 0, 0, 0, 0);
        step();
        check("rst_mid_cyc_pre", {31'd0, iwbm_cyc}, 32'd1);
        drive(1, 0, 32'h0, 0, 0, 0, 0, 0);
        step();
        check("rst_mid_cyc", {30'd0, iwbm_cyc, busy}, 32'd0);
        check("rst_addr", iwbm_addr, 32'h0);
        check("rst_insn", instruction, NOP);
        check("rst_pc", fetch_pc_out, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 1, 0, 32'h88888888);
        step();
        check("rst_stray_ack", {28'd0, instruction_valid, fault_valid, iwbm_cyc, busy}, 32'd0);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0);

`ifdef TITAN_FETCH_TIMEOUT_EN
        // No ack: bus cycle must be abandoned after 8 cycles with an access fault
        drive(0, 1, 32'h800, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0);
        cyc_cnt = 0;
        for (int i = 0; i < 20 && iwbm_cyc; i++) begin
            cyc_cnt++;
            step();
        end
        check("tmo_cycles", cyc_cnt, 32'd8);
        check("tmo_fault", {27'd0, fault_valid, fault_code}, {27'd0, 1'b1, 4'd1});
        step();
`else
        cyc_cnt = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/titan_fetch_unit.md
TITAN_FETCH_UNIT -- requirements
Module: titan_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_ADDR, 32'h0000_0000, PC reported on fetch_pc_o after reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 255, bus-wait limit in cycles, range 1..255, used only under TITAN_FETCH_TIMEOUT_EN.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fetch_req_i  input  1  IF stage requests a fetch at fetch_pc_i.
REQ-006 SHALL have port fetch_pc_i  input  32  fetch address.
REQ-007 SHALL have port fetch_stall_i  input  1  IF/ID cannot accept a result this cycle.
REQ-008 SHALL have port fetch_kill_i  input  1  flush: discard the pending or held fetch.
REQ-009 SHALL have port instruction_o  output  32  fetched word.
REQ-010 SHALL have port fetch_pc_o  output  32  PC of the current result.
REQ-011 SHALL have port instruction_valid_o  output  1  result valid, no fault.
REQ-012 SHALL have port fault_valid_o  output  1  result is a fault, not an instruction.
REQ-013 SHALL have port fault_code_o  output  4  0 = misaligned fetch, 1 = access fault.
REQ-014 SHALL have port busy_o  output  1  unit not in IDLE.
REQ-015 SHALL have ports iwbm_addr_o (o, 32), iwbm_cyc_o (o, 1), iwbm_stb_o (o, 1), iwbm_dat_i (i, 32), iwbm_ack_i (i, 1), iwbm_err_i (i, 1): Wishbone classic read master.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, HOLD, DISCARD.
REQ-017 In IDLE with fetch_req_i=1, fetch_kill_i=0 and fetch_pc_i[1:0]=0, SHALL latch the PC, go to WAIT, and drive cyc/stb=1 and addr=PC from the next cycle.
REQ-018 In IDLE with fetch_req_i=1 and fetch_pc_i[1:0]!=0, SHALL issue no bus cycle and present fault_valid_o=1 with code 0 in the next cycle.
REQ-019 In WAIT, cyc/stb SHALL stay high and addr SHALL stay stable until ack or err; both SHALL be dropped in the cycle after ack/err.
REQ-020 On ack in WAIT, SHALL register iwbm_dat_i and assert instruction_valid_o the next cycle (ack-to-valid latency 1).
REQ-021 On err in WAIT, or on ack and err together, SHALL report fault_valid_o=1 with code 1; err SHALL win over ack.
REQ-022 If fetch_stall_i=1 when a result becomes valid, SHALL go to HOLD and keep the outputs stable until fetch_stall_i=0; the result SHALL be consumed in the first cycle with fetch_stall_i=0.
REQ-023 instruction_valid_o and fault_valid_o SHALL never be high together and SHALL each be high for exactly one consumed cycle per request.
REQ-024 fetch_kill_i in WAIT SHALL move to DISCARD; DISCARD SHALL keep cyc/stb high until ack/err, drop the response and return to IDLE with no output.
REQ-025 fetch_kill_i in the same cycle as ack/err in WAIT SHALL drop the response and go to IDLE.
REQ-026 fetch_kill_i in HOLD SHALL clear the outputs and go to IDLE the next cycle.
REQ-027 fetch_kill_i in IDLE SHALL suppress the new request.
REQ-028 A request in the cycle a result is consumed SHALL be accepted without an extra idle cycle (back-to-back fetch, one word per two cycles minimum).

Reset
REQ-029 On rst_i, SHALL set state=IDLE, cyc/stb=0, iwbm_addr_o=RESET_ADDR, fetch_pc_o=RESET_ADDR, instruction_o=32'h0000_0013 (NOP), all valid/fault/busy outputs 0, fault_code_o=0.
REQ-030 rst_i mid-bus-cycle SHALL drop cyc/stb in the next cycle and ignore any later ack.

Configuration
REQ-031 With TITAN_FETCH_TIMEOUT_EN defined, WAIT/DISCARD SHALL count cycles; on reaching TIMEOUT_CYCLES without ack/err, SHALL drop cyc/stb and report code 1 (WAIT) or silently go to IDLE (DISCARD).
REQ-032 Without TITAN_FETCH_TIMEOUT_EN, SHALL contain no counter and wait indefinitely.

Structure
REQ-033 FSM state enum, fault codes and the NOP constant SHALL live in shared package titan_pkg.
REQ-034 The timeout counter SHALL be the sub-module titan_fetch_timeout (start, clear, expired), instantiated only under the macro.

Verification
REQ-035 Fetch 0x100, ack after 3 cycles with 0x00500093 -> instruction_valid_o=1, instruction_o=0x00500093, fetch_pc_o=0x100, one cycle after ack.
REQ-036 Fetch 0x102 -> no cyc; fault_valid_o=1, code 0, next cycle.
REQ-037 Fetch 0x200, err on 2nd cycle -> fault_valid_o=1, code 1; ack+err together -> code 1.
REQ-038 Kill in WAIT, ack 4 cycles later -> no valid output, busy_o=0 after ack; new fetch 0x300 then proceeds normally.
REQ-039 Result with fetch_stall_i=1 for 5 cycles -> outputs stable for 5 cycles, consumed once; kill during HOLD -> cleared.
REQ-040 With the macro and TIMEOUT_CYCLES=8, no ack -> cyc drops after 8 cycles, fault code 1.
